// File: rtl/deser_pkg.sv
// Shared constants and state encoding for the serial-to-parallel receiver.
package deser_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned MIN_LEN = 3;

  typedef enum logic {
    IDLE,
    RECV
  } deser_state_t;

endpackage

// File: rtl/deserializer.sv
// Collects an MSB-first serial run into a parallel word with a serializer-style bit count.
module deserializer
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned MIN_LEN = deser_pkg::MIN_LEN
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ser_data_i,
  input  logic             ser_data_val_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic [3:0]       deser_data_mod_o,
  output logic             deser_data_val_o,
  output logic             err_o
);

  deser_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;

  logic [WIDTH-1:0] ins;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       pos;

  always_comb begin
    cnt_inc  = cnt + 1'b1;
    pos      = 4'(WIDTH - 1) - cnt[3:0];
    ins      = shreg;
    ins[pos] = ser_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      cnt              <= '0;
      shreg            <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      err_o            <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ser_data_val_i) begin
            // frame start clears stale bits so short frames read back zero-filled
            shreg <= {ser_data_i, {(WIDTH - 1){1'b0}}};
            cnt   <= CNT_W'(1);
            state <= RECV;
          end
        end
        RECV: begin
          if (ser_data_val_i) begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
              // 16th bit: count wraps to 0 in the 4-bit mod encoding
              deser_data_o     <= ins;
              deser_data_mod_o <= cnt_inc[3:0];
              deser_data_val_o <= 1'b1;
              shreg            <= ins;
              cnt              <= '0;
              state            <= IDLE;
            end else begin
              shreg <= ins;
              cnt   <= cnt_inc;
            end
          end else begin
            if (cnt >= CNT_W'(MIN_LEN)) begin
              deser_data_o     <= shreg;
              deser_data_mod_o <= cnt[3:0];
              deser_data_val_o <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the team's 16-bit serializer.
- Collects a serial bit stream (MSB first, framed by a valid strobe) into a parallel word, with a bit count in the same encoding as the serializer's data_mod_i.
- Sits at the far end of the serial link and feeds parallel consumers with a one-cycle valid pulse per word.
- Flags runs that are too short to be legal serializer frames.

Parameters:
- WIDTH, 16: maximum word length in bits. Only 16 is required; other widths are not supported in this revision.
- MIN_LEN, 3: shortest legal run. Shorter runs are dropped and flagged.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- ser_data_i  in  1  serial data bit, sampled when ser_data_val_i=1
- ser_data_val_i  in  1  bit valid; a contiguous high run is one frame
- deser_data_o  out  16  assembled word. First received bit is at [15]; unreceived LSBs are 0.
- deser_data_mod_o  out  4  number of bits in the word, 3..15; 0 encodes 16
- deser_data_val_o  out  1  one-cycle pulse, word/mod valid
- err_o  out  1  one-cycle pulse, run shorter than MIN_LEN dropped

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - all outputs 0, state IDLE, bit count 0, shift register 0.
  - Takes effect immediately, even mid-frame.
  - The partial frame is discarded; no val or err pulse is produced.
- FSM states: IDLE, RECV.
- IDLE:
  - on ser_data_val_i=1: store the bit at position 15, set count=1, go to RECV.
  - otherwise stay in IDLE.
- RECV, ser_data_val_i=1 and count<15: store the bit at position 15-count, then count+1.
- RECV, ser_data_val_i=1 and count==15 (16th bit): store the bit at [0] and complete the frame with mod=0.
  - Next state is IDLE.
  - A valid bit on the following cycle starts a new frame with no gap. This matches 16-bit back-to-back traffic.
- RECV, ser_data_val_i=0 (end of run): complete the frame with mod=count, then go to IDLE.
- Frame completion, registered, visible the cycle after the completing edge:
  - count>=MIN_LEN, or a full 16-bit frame:
    - deser_data_o = the assembled word, with unfilled LSBs zero;
    - deser_data_mod_o = count[3:0];
    - deser_data_val_o = 1 for exactly one cycle.
  - count<MIN_LEN:
    - err_o = 1 for one cycle;
    - deser_data_o, deser_data_mod_o and deser_data_val_o are unchanged and not asserted.
- Latency:
  - Full 16-bit frame: deser_data_val_o high 1 cycle after the 16th valid bit.
  - Partial frame: deser_data_val_o high 1 cycle after the first low cycle of ser_data_val_i.
- Output hold: deser_data_o and deser_data_mod_o hold their last completed value until the next completion. Only the val and err pulses return to 0.
- Shift register: cleared on every frame start, so stale bits never leak into short frames.
- Simultaneous events: a 16th-bit completion and a new frame start can never coincide. The new frame begins on the next valid cycle.
- ser_data_i is ignored whenever ser_data_val_i=0.
- Count width: 5-bit internally (0..16). Bits [3:0] are presented, so 16 maps to 0.

Decomposition:
- Package deser_pkg holds:
  - localparam DATA_W=16;
  - CNT_W=5;
  - MIN_LEN=3;
  - typedef enum logic {IDLE, RECV} deser_state_t.
- Single flat module; no sub-module is needed. The FSM, counter and bit-insert logic fit in one always_ff block plus one always_comb block.
- Bench reuses the existing serializer as the stimulus source for loopback.

Test Plan:
- Full frame: 16 valid bits of 0xA5C3 MSB first, then val low -> 1 cycle after the 16th bit, deser_data_o=0xA5C3, mod=0, val pulse 1 cycle, err_o=0.
- Partial frame: 5 bits 1,0,1,1,0 then val low -> deser_data_o=0xB000, mod=5, val pulse 1 cycle after the low cycle.
- Back-to-back: 32 continuous valid bits, 0x1234 then 0xFFFF -> two val pulses 16 cycles apart, words 0x1234 then 0xFFFF, mod=0 each.
- Short run: 2 valid bits then low -> err_o pulse 1 cycle, no val pulse; outputs keep their previous word and mod.
- Async reset mid-frame: rst_ni low after 7 bits, between clock edges -> outputs 0 immediately. After release, a new 4-bit frame 1111 gives 0xF000, mod=4, with no residue from the aborted frame.
- Loopback: serializer sends data_i=0xBEEF, data_mod_i=9 -> output word equals the top 9 bits of 0xBEEF with the LSBs zero (0xBE80), mod=9.
